// File: rtl/maxpool_scheduler_pkg.sv
// Shared types and width helpers for the pooling-layer scheduler slice.
package maxpool_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } sched_state_t;

    // Never returns 0 so degenerate sizes still give a legal vector width.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    function automatic int in_addr_w(input int num_ch, input int map_width);
        return clog2_min1(num_ch * map_width * map_width);
    endfunction

    function automatic int out_addr_w(input int num_ch, input int map_width);
        return clog2_min1(num_ch * (map_width / 2) * (map_width / 2));
    endfunction

endpackage

// File: rtl/maxpool_scheduler_if.sv
// Bus bundle between the scheduler, the conv output RAM, the pooling engine and the pool output RAM.
interface maxpool_scheduler_if
    import maxpool_pkg::*;
#(
    parameter int MAP_WIDTH = 28,
    parameter int NUM_CH    = 6
) ();

    localparam int IN_AW  = in_addr_w(NUM_CH, MAP_WIDTH);
    localparam int OUT_AW = out_addr_w(NUM_CH, MAP_WIDTH);

    logic                    in_rd_en;
    logic [IN_AW-1:0]        in_addr;
    logic signed [7:0]       in_rdata;
    logic                    pool_rst;
    logic                    pool_valid;
    logic signed [7:0]       pool_pixel;
    logic                    pool_valid_out;
    logic signed [7:0]       pool_pixel_out;
    logic                    pool_all_done;
    logic                    out_we;
    logic [OUT_AW-1:0]       out_addr;
    logic signed [7:0]       out_data;

    modport master (
        output in_rd_en, in_addr, pool_rst, pool_valid, pool_pixel,
               out_we, out_addr, out_data,
        input  in_rdata, pool_valid_out, pool_pixel_out, pool_all_done
    );

    modport slave (
        input  in_rd_en, in_addr, pool_rst, pool_valid, pool_pixel,
               out_we, out_addr, out_data,
        output in_rdata, pool_valid_out, pool_pixel_out, pool_all_done
    );

endinterface

// File: rtl/maxpool_scheduler_addr_gen.sv
// Pixel/pooled-pixel counters and running channel bases for the input and output RAM addresses.
module maxpool_addr_gen
    import maxpool_pkg::*;
#(
    parameter int MAP_WIDTH = 28,
    parameter int NUM_CH    = 6,
    parameter int OUT_DIM   = MAP_WIDTH / 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      clear_i,
    input  logic                                      next_ch_i,
    input  logic                                      advance_base_i,
    input  logic                                      pix_inc_i,
    input  logic                                      opix_inc_i,
    output logic [in_addr_w(NUM_CH, MAP_WIDTH)-1:0]   in_addr_o,
    output logic [out_addr_w(NUM_CH, MAP_WIDTH)-1:0]  out_addr_o,
    output logic                                      last_pix_o,
    output logic                                      last_opix_o
);

    localparam int IN_AW  = in_addr_w(NUM_CH, MAP_WIDTH);
    localparam int OUT_AW = out_addr_w(NUM_CH, MAP_WIDTH);
    localparam int PIX_W  = clog2_min1(MAP_WIDTH * MAP_WIDTH);
    localparam int OPIX_W = clog2_min1(OUT_DIM * OUT_DIM + 1);

    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [OPIX_W-1:0] opix_q, opix_d;
    logic [IN_AW-1:0]  in_base_q, in_base_d;
    logic [OUT_AW-1:0] out_base_q, out_base_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q      <= '0;
            opix_q     <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
        end else begin
            pix_q      <= pix_d;
            opix_q     <= opix_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
        end
    end

    // Channel bases step by one map size on each channel change, so no multiplier is needed.
    always_comb begin
        pix_d      = pix_q;
        opix_d     = opix_q;
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        if (clear_i || next_ch_i) begin
            pix_d  = '0;
            opix_d = '0;
        end else begin
            if (pix_inc_i) pix_d = pix_q + PIX_W'(1);
            if (opix_inc_i) opix_d = opix_q + OPIX_W'(1);
        end
        if (clear_i) begin
            in_base_d  = '0;
            out_base_d = '0;
        end else if (advance_base_i) begin
            in_base_d  = in_base_q + IN_AW'(MAP_WIDTH * MAP_WIDTH);
            out_base_d = out_base_q + OUT_AW'(OUT_DIM * OUT_DIM);
        end
    end

    assign in_addr_o   = in_base_q + IN_AW'(pix_q);
    assign out_addr_o  = out_base_q + OUT_AW'(opix_q);
    assign last_pix_o  = (pix_q == PIX_W'(MAP_WIDTH * MAP_WIDTH - 1));
    // High once every pooled pixel of the current channel has been written.
    assign last_opix_o = (opix_q == OPIX_W'(OUT_DIM * OUT_DIM));

endmodule

// File: rtl/maxpool_scheduler.sv
// Sequences NUM_CH feature maps through one shared 2x2/stride-2 pooling engine.
module maxpool_scheduler
    import maxpool_pkg::*;
#(
    parameter int MAP_WIDTH = 28,
    parameter int NUM_CH    = 6,
    localparam int OUT_DIM  = MAP_WIDTH / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 hold,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    maxpool_scheduler_if.master  bus
);

    localparam int IN_AW  = in_addr_w(NUM_CH, MAP_WIDTH);
    localparam int OUT_AW = out_addr_w(NUM_CH, MAP_WIDTH);
    localparam int CH_W   = clog2_min1(NUM_CH);

    sched_state_t      state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              err_q, err_d;
    logic              pool_valid_q;
    logic              all_done_q;
    logic              rd_en;
    logic              last_ch;
    logic              last_pix;
    logic              opix_full;
    logic              all_done_rise;
    logic [IN_AW-1:0]  in_addr;
    logic [OUT_AW-1:0] out_addr;

    assign last_ch       = (ch_q == CH_W'(NUM_CH - 1));
    assign rd_en         = (state_q == S_STREAM) && !hold;
    assign all_done_rise = bus.pool_all_done && !all_done_q;

    maxpool_addr_gen #(
        .MAP_WIDTH (MAP_WIDTH),
        .NUM_CH    (NUM_CH),
        .OUT_DIM   (OUT_DIM)
    ) u_addr_gen (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (state_q == S_IDLE),
        .next_ch_i      (state_q == S_NEXT),
        .advance_base_i ((state_q == S_NEXT) && !last_ch),
        .pix_inc_i      (rd_en),
        .opix_inc_i     (bus.pool_valid_out && !opix_full),
        .in_addr_o      (in_addr),
        .out_addr_o     (out_addr),
        .last_pix_o     (last_pix),
        .last_opix_o    (opix_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ch_q         <= '0;
            err_q        <= 1'b0;
            pool_valid_q <= 1'b0;
            all_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            err_q        <= err_d;
            pool_valid_q <= rd_en;
            all_done_q   <= bus.pool_all_done;
        end
    end

    // Layer sequencing; err is only judged while a layer is in flight and cleared by a new start.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                ch_d = '0;
                if (start) begin
                    state_d = S_CLEAR;
                    err_d   = 1'b0;
                end
            end
            S_CLEAR:  state_d = S_STREAM;
            S_STREAM: if (rd_en && last_pix) state_d = S_DRAIN;
            S_DRAIN:  if (bus.pool_all_done) state_d = S_NEXT;
            S_NEXT: begin
                if (last_ch) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_CLEAR;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE) begin
            if ((all_done_rise && !opix_full) || (bus.pool_valid_out && opix_full)) err_d = 1'b1;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign err            = err_q;
    assign bus.in_rd_en   = rd_en;
    assign bus.in_addr    = in_addr;
    assign bus.pool_rst   = rst || (state_q == S_CLEAR);
    assign bus.pool_valid = pool_valid_q;
    assign bus.pool_pixel = bus.in_rdata;
    assign bus.out_we     = bus.pool_valid_out;
    assign bus.out_addr   = out_addr;
    assign bus.out_data   = bus.pool_pixel_out;

endmodule

// File: tb/tb_maxpool_scheduler.sv
// Directed bench: 4x4 maps, 2 channels, behavioural RAMs and a behavioural 2x2 max-pool engine.
module tb_maxpool_scheduler;

    localparam int MW = 4;
    localparam int NC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic hold = 1'b0;
    logic busy, done, err;

    maxpool_scheduler_if #(.MAP_WIDTH(MW), .NUM_CH(NC)) bus ();

    maxpool_scheduler #(.MAP_WIDTH(MW), .NUM_CH(NC)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .hold  (hold),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Input RAM: one-cycle read latency
    logic signed [7:0] in_mem [0:31];
    logic signed [7:0] rdata = '0;
    always @(posedge clk) if (bus.in_rd_en) rdata <= in_mem[bus.in_addr];
    assign bus.in_rdata = rdata;

    // Pooling engine model
    function automatic logic signed [7:0] max4(input logic signed [7:0] a, b, c, d);
        logic signed [7:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    logic signed [7:0] win [0:15];
    int   eng_cnt = 0;
    int   eng_outs = 0;
    logic vo = 1'b0;
    logic ad = 1'b0;
    logic signed [7:0] po = '0;
    bit   force_early = 1'b0;
    always @(posedge clk) begin
        if (bus.pool_rst) begin
            eng_cnt <= 0; eng_outs <= 0; vo <= 1'b0; ad <= 1'b0; po <= '0;
        end else begin
            vo <= 1'b0;
            if (bus.pool_valid) begin
                win[eng_cnt] <= bus.pool_pixel;
                eng_cnt <= eng_cnt + 1;
                if (((eng_cnt / MW) % 2 == 1) && ((eng_cnt % MW) % 2 == 1)) begin
                    vo <= 1'b1;
                    po <= max4(win[eng_cnt-MW-1], win[eng_cnt-MW], win[eng_cnt-1], bus.pool_pixel);
                    eng_outs <= eng_outs + 1;
                end
            end
            if (vo && (eng_outs == 4 || (force_early && eng_outs == 2))) ad <= 1'b1;
        end
    end
    assign bus.pool_valid_out = vo;
    assign bus.pool_pixel_out = po;
    assign bus.pool_all_done  = ad;

    // Output RAM and event log
    logic clr_log = 1'b0;
    logic signed [7:0] out_mem [0:7];
    int rd_cnt [0:31];
    int wr_cnt = 0, done_cnt = 0, clr_cnt = 0;
    always @(posedge clk) begin
        if (clr_log) begin
            wr_cnt <= 0; done_cnt <= 0; clr_cnt <= 0;
            for (int i = 0; i < 32; i++) rd_cnt[i] <= 0;
            for (int i = 0; i < 8; i++) out_mem[i] <= 8'sh11;
        end else begin
            if (bus.out_we) begin
                out_mem[bus.out_addr] <= bus.out_data;
                wr_cnt <= wr_cnt + 1;
            end
            if (bus.in_rd_en) rd_cnt[bus.in_addr] <= rd_cnt[bus.in_addr] + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (bus.pool_rst && !rst) clr_cnt <= clr_cnt + 1;
        end
    end

    task automatic load_ramp();
        for (int i = 0; i < 32; i++) in_mem[i] = 8'(i);
    endtask

    task automatic pulse_clr_log();
        @(negedge clk); clr_log = 1'b1;
        @(negedge clk); clr_log = 1'b0;
    endtask

    // Runs one layer from a start pulse; records first-event cycles relative to the start cycle.
    task automatic run_layer(input bit use_hold, input bit poke_start,
                             output int done_cyc, output int rd_cyc, output int pv_cyc,
                             output int clr_cyc, output logic err_c1);
        done_cyc = -1; rd_cyc = -1; pv_cyc = -1; clr_cyc = -1; err_c1 = 1'bx;
        pulse_clr_log();
        start = 1'b1;
        for (int k = 1; k <= 400 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (k == 1) err_c1 = err;
            if (bus.pool_rst && clr_cyc < 0) clr_cyc = k;
            if (bus.in_rd_en && rd_cyc < 0) rd_cyc = k;
            if (bus.pool_valid && pv_cyc < 0) pv_cyc = k;
            if (done) done_cyc = k;
            start = poke_start && (k == 9 || k == 30);
            if (use_hold) hold = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        hold  = 1'b0;
        @(negedge clk);
        checks++;
        if (done_cyc < 0) $display("[TB] FAIL run_timeout: done not seen, required within 400 cycles");
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", done); else passed++;
        checks++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", err); else passed++;
        checks++; if (bus.in_rd_en !== 1'b0) $display("[TB] FAIL reset_rd_en: got %b want 0", bus.in_rd_en); else passed++;
        checks++; if (bus.pool_valid !== 1'b0) $display("[TB] FAIL reset_pool_valid: got %b want 0", bus.pool_valid); else passed++;
        checks++; if (bus.out_we !== 1'b0) $display("[TB] FAIL reset_out_we: got %b want 0", bus.out_we); else passed++;
        checks++; if (bus.in_addr !== 5'd0) $display("[TB] FAIL reset_in_addr: got %0d want 0", bus.in_addr); else passed++;
        checks++; if (bus.out_addr !== 3'd0) $display("[TB] FAIL reset_out_addr: got %0d want 0", bus.out_addr); else passed++;
        checks++; if (bus.pool_rst !== 1'b1) $display("[TB] FAIL reset_pool_rst: got %b want 1", bus.pool_rst); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int dc, rc, pc, cc;
        logic e1;
        logic signed [7:0] expv [8] = '{8'sd5, 8'sd7, 8'sd13, 8'sd15, 8'sd21, 8'sd23, 8'sd29, 8'sd31};
        load_ramp();
        run_layer(1'b0, 1'b0, dc, rc, pc, cc, e1);
        checks++; if (cc !== 1) $display("[TB] FAIL basic_clear_cycle: got %0d want 1", cc); else passed++;
        checks++; if (rc !== 2) $display("[TB] FAIL basic_first_rd_cycle: got %0d want 2", rc); else passed++;
        checks++; if (pc !== 3) $display("[TB] FAIL basic_first_pool_valid_cycle: got %0d want 3", pc); else passed++;
        checks++; if (dc !== 43) $display("[TB] FAIL basic_done_cycle: got %0d want 43", dc); else passed++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_mem[i] !== expv[i]) $display("[TB] FAIL basic_out[%0d]: got %0d want %0d", i, out_mem[i], expv[i]);
            else passed++;
        end
        checks++; if (wr_cnt !== 8) $display("[TB] FAIL basic_write_count: got %0d want 8", wr_cnt); else passed++;
        checks++; if (done_cnt !== 1) $display("[TB] FAIL basic_done_count: got %0d want 1", done_cnt); else passed++;
        checks++; if (clr_cnt !== 2) $display("[TB] FAIL multi_clear_pulses: got %0d want 2", clr_cnt); else passed++;
        checks++; if (err !== 1'b0) $display("[TB] FAIL basic_err: got %b want 0", err); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL basic_busy_after: got %b want 0", busy); else passed++;
    endtask

    task automatic test_signed();
        int dc, rc, pc, cc;
        logic e1;
        for (int i = 0; i < 32; i++) in_mem[i] = -8'sd128;
        in_mem[5] = -8'sd1;
        run_layer(1'b0, 1'b0, dc, rc, pc, cc, e1);
        checks++; if (out_mem[0] !== -8'sd1) $display("[TB] FAIL signed_out[0]: got %0d want -1", out_mem[0]); else passed++;
        for (int i = 1; i < 8; i++) begin
            checks++;
            if (out_mem[i] !== -8'sd128) $display("[TB] FAIL signed_out[%0d]: got %0d want -128", i, out_mem[i]);
            else passed++;
        end
    endtask

    task automatic test_start_while_busy();
        int dc, rc, pc, cc;
        logic e1;
        load_ramp();
        run_layer(1'b0, 1'b1, dc, rc, pc, cc, e1);
        checks++; if (dc !== 43) $display("[TB] FAIL busy_start_done_cycle: got %0d want 43", dc); else passed++;
        checks++; if (done_cnt !== 1) $display("[TB] FAIL busy_start_done_count: got %0d want 1", done_cnt); else passed++;
        checks++; if (out_mem[6] !== 8'sd29) $display("[TB] FAIL busy_start_out[6]: got %0d want 29", out_mem[6]); else passed++;
    endtask

    task automatic test_hold();
        int dc, rc, pc, cc, bad_rd;
        logic e1;
        logic signed [7:0] expv [8] = '{8'sd5, 8'sd7, 8'sd13, 8'sd15, 8'sd21, 8'sd23, 8'sd29, 8'sd31};
        load_ramp();
        run_layer(1'b1, 1'b0, dc, rc, pc, cc, e1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_mem[i] !== expv[i]) $display("[TB] FAIL hold_out[%0d]: got %0d want %0d", i, out_mem[i], expv[i]);
            else passed++;
        end
        bad_rd = 0;
        for (int i = 0; i < 32; i++) if (rd_cnt[i] != 1) bad_rd++;
        checks++; if (bad_rd !== 0) $display("[TB] FAIL hold_read_once: %0d addresses not read exactly once, want 0", bad_rd); else passed++;
        checks++; if (wr_cnt !== 8) $display("[TB] FAIL hold_write_count: got %0d want 8", wr_cnt); else passed++;
    endtask

    task automatic test_reset_mid_run();
        int dc, rc, pc, cc;
        bit seen;
        logic e1;
        load_ramp();
        pulse_clr_log();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            if (bus.in_rd_en && bus.in_addr == 5'd9) seen = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!seen) $display("[TB] FAIL midrst_reach_pix9: got no read of 9, want read of 9"); else passed++;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b want 0", busy); else passed++;
        checks++; if (bus.in_rd_en !== 1'b0) $display("[TB] FAIL midrst_rd_en: got %b want 0", bus.in_rd_en); else passed++;
        checks++; if (bus.pool_rst !== 1'b1) $display("[TB] FAIL midrst_pool_rst: got %b want 1", bus.pool_rst); else passed++;
        rst = 1'b0;
        pulse_clr_log();
        repeat (10) @(negedge clk);
        checks++; if (wr_cnt !== 0) $display("[TB] FAIL midrst_writes: got %0d want 0", wr_cnt); else passed++;
        checks++; if (done_cnt !== 0) $display("[TB] FAIL midrst_done: got %0d want 0", done_cnt); else passed++;
        run_layer(1'b0, 1'b0, dc, rc, pc, cc, e1);
        checks++; if (dc !== 43) $display("[TB] FAIL midrst_restart_done_cycle: got %0d want 43", dc); else passed++;
        checks++; if (out_mem[0] !== 8'sd5) $display("[TB] FAIL midrst_restart_out[0]: got %0d want 5", out_mem[0]); else passed++;
        checks++; if (out_mem[7] !== 8'sd31) $display("[TB] FAIL midrst_restart_out[7]: got %0d want 31", out_mem[7]); else passed++;
    endtask

    task automatic test_error();
        int dc, rc, pc, cc;
        logic e1;
        load_ramp();
        force_early = 1'b1;
        run_layer(1'b0, 1'b0, dc, rc, pc, cc, e1);
        checks++; if (err !== 1'b1) $display("[TB] FAIL err_set: got %b want 1", err); else passed++;
        repeat (5) @(negedge clk);
        checks++; if (err !== 1'b1) $display("[TB] FAIL err_sticky: got %b want 1", err); else passed++;
        force_early = 1'b0;
        run_layer(1'b0, 1'b0, dc, rc, pc, cc, e1);
        checks++; if (e1 !== 1'b0) $display("[TB] FAIL err_clear_on_start: got %b want 0", e1); else passed++;
        checks++; if (err !== 1'b0) $display("[TB] FAIL err_clean_run: got %b want 0", err); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_start_while_busy();
        test_hold();
        test_reset_mid_run();
        test_error();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/maxpool_scheduler.md
# maxpool_scheduler

Sequences a multi-channel pooling layer through one shared 2x2/stride-2 `maxpool_engine`. On `start` it clears the engine, then streams each channel's `MAP_WIDTH x MAP_WIDTH` feature map from the conv output buffer into the engine. It writes the engine's pooled pixels to the pool output buffer at channel-offset addresses and pulses `done` when every channel is finished. It sits between the conv-layer output RAM and the next layer's input RAM.

## Interface
- `MAP_WIDTH`, 28, input map side (even); engine instantiated with same value
- `NUM_CH`, 6, channels processed per `start`
- `OUT_DIM`, `MAP_WIDTH/2`, pooled map side (derived, do not override)
- `clk` in 1, clock
- `rst` in 1, reset: synchronous, active-high
- `start` in 1, begin layer; sampled only in IDLE
- `hold` in 1, upstream pause; freezes read issue while high
- `busy` out 1, high from accepted `start` until `done`
- `done` out 1, one-cycle pulse after last channel
- `err` out 1, sticky protocol error; cleared by `rst` or accepted `start`
- `in_rd_en` out 1, input RAM read strobe
- `in_addr` out `$clog2(NUM_CH*MAP_WIDTH*MAP_WIDTH)`, `ch*MAP_WIDTH^2 + pix`
- `in_rdata` in 8 signed, valid exactly 1 cycle after `in_rd_en`
- `pool_rst` out 1, engine reset; high while `rst` or in CLEAR
- `pool_valid` out 1, engine `valid_in`
- `pool_pixel` out 8 signed, engine `pixel_in`
- `pool_valid_out` in 1, engine `valid_out`
- `pool_pixel_out` in 8 signed, engine `pixel_out`
- `pool_all_done` in 1, engine `all_done`
- `out_we` out 1, output RAM write strobe
- `out_addr` out `$clog2(NUM_CH*OUT_DIM*OUT_DIM)`, `ch*OUT_DIM^2 + opix`
- `out_data` out 8 signed, pooled value

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, NEXT, DONE.
- IDLE:
  - `start` -> CLEAR.
  - `ch`, `pix`, and `opix` are zeroed and `err` is cleared.
- CLEAR: `pool_rst=1` for exactly 1 cycle -> STREAM.
- STREAM:
  - On each cycle with `hold=0`: assert `in_rd_en`, drive `in_addr`, increment `pix`.
  - After the read of `pix = MAP_WIDTH^2-1` -> DRAIN.
  - `hold=1` issues no read and freezes `pix`.
  - A read already in flight still completes the following cycle.
- DRAIN:
  - Waits for `pool_all_done`.
  - Then -> NEXT.
- NEXT: `ch==NUM_CH-1` -> DONE; else `ch++`, `pix=0`, `opix=0` -> CLEAR.
- DONE: `done=1` for one cycle -> IDLE.
- `busy` = state != IDLE.
- Feed path:
  - `pool_valid` is registered `in_rd_en`.
  - `pool_pixel` = `in_rdata`, passed straight through.
- Write path:
  - `out_we = pool_valid_out` (combinational).
  - `out_data = pool_pixel_out`, `out_addr = ch*OUT_DIM^2 + opix`.
  - `opix` increments on each `out_we`.
  - The engine has no backpressure, so the output RAM must accept every cycle.
- Error conditions: `err` sets if either of the following occurs.
  - `pool_all_done` rises before `opix` reaches `OUT_DIM^2`.
  - `pool_valid_out` arrives when `opix == OUT_DIM^2`.
- `start` is ignored while `busy`. `hold` is ignored outside STREAM.
- Address arithmetic is unsigned. The `ch*constant` offsets are computed by adding a running base register on NEXT, not with a multiplier.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `err`, `in_rd_en`, `pool_valid`, `out_we` = 0.
  - `in_addr`, `out_addr` = 0.
  - `pool_rst` = 1 (follows `rst`).
- `start` at cycle 0: CLEAR at cycle 1, first `in_rd_en` at cycle 2, first `pool_valid` at cycle 3.
- Engine output: `pool_valid_out` 1 cycle after the `pool_valid` of the bottom-right window pixel. The write occurs in the same cycle.
- Last output of a channel: `pool_all_done` is seen 1 cycle later. Per-channel overhead beyond the `MAP_WIDTH^2` read cycles is CLEAR + DRAIN + NEXT, about 5 cycles.
- With `hold=0` throughout: total latency = `NUM_CH*(MAP_WIDTH^2 + ~5) + 2` cycles.
- Reset mid-operation:
  - Returns to IDLE next edge and drops all strobes.
  - Resets the engine through `pool_rst`.
  - No partial `done`.
- Simultaneous `hold` rise and the last read: a read is issued only if `hold=0` that cycle.

## Structure
- `maxpool_pkg`: `sched_state_t` enum; width helper functions for `in_addr`/`out_addr`.
- One natural sub-module, `maxpool_addr_gen`:
  - Owns the `pix`/`opix` counters and the channel base registers.
  - Emits `in_addr`/`out_addr` and `last_pix`/`last_opix` flags.
- FSM stays in `maxpool_scheduler`.
- The engine is instantiated beside the scheduler by the layer top, not inside it.

## Test plan
- Basic:
  - Stimulus: `MAP_WIDTH=4`, `NUM_CH=1`, ch0 = ramp 0..15.
  - Required: writes 5, 7, 13, 15 at `out_addr` 0..3, `done` once, `err=0`.
- Signed data:
  - Stimulus: all pixels -128 except pixel 5 = -1.
  - Required: out[0] = -1, out[1..3] = -128.
- Multi-channel:
  - Stimulus: `NUM_CH=2`, ch1 = ramp+16.
  - Required: ch1 writes 21, 23, 29, 31 at `out_addr` 4..7; one CLEAR `pool_rst` pulse per channel.
- Hold:
  - Stimulus: `hold` toggled pseudo-randomly during STREAM.
  - Required: identical output values/addresses to the unheld run; no duplicate `in_addr`.
- Start/reset:
  - `start` while `busy`: ignored.
  - `rst` asserted at pixel 9 of ch0: required IDLE, no writes.
  - Fresh `start` after the reset: correct full results.
- Error:
  - Stimulus: bench model forces `pool_all_done` early after 2 outputs.
  - Required: `err` sets and stays set until the next `start`.
